fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. Owns the architectural PC register, drives the instruction-memory request handshake, and presents fetched instructions to decode under a valid/ready handshake. Controls the NPC next-address unit by driving its PC, immediate and `npcop` inputs, then commits the returned address on sequential advance, taken branch or jump.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address; always equals the PC register.
- `imem_ack`  in  1  read data valid; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `instr_valid`  out  1  held instruction available to decode.
- `instr`  out  32  held instruction word.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  decode accepts; transfer when `instr_valid`&`instr_ready`.
- `br_valid`  in  1  branch resolved this cycle.
- `br_taken`  in  1  branch outcome; ignored unless `br_valid`.
- `br_pc`  in  32  address of the resolved branch.
- `br_imm16`  in  16  branch offset field.
- `j_valid`  in  1  jump resolved this cycle.
- `j_imm26`  in  26  jump target field.
- `npc_pc`  out  32  PC input to NPC.
- `npc_imm16`  out  16  imm16 to NPC.
- `npc_imm26`  out  26  imm26 to NPC.
- `npc_op`  out  2  NPC op: 00 sequential, 01 branch, 10 jump.
- `npc_in`  in  32  NPC result; combinational in the same cycle.

## Operation
- States: IDLE, FETCH, HOLD. Registers: `pc`, `instr`, `instr_pc`, `redir_pend`, `redir_tgt`.
- IDLE: one cycle after reset, then FETCH.
- FETCH: `imem_req`=1. On `imem_ack`: latch `imem_rdata`→`instr`, `pc`→`instr_pc`, then go to HOLD. If `redir_pend` is set with the kill flag, discard the data, set `pc`←`redir_tgt`, clear pending, and stay in FETCH (new request).
- HOLD: `instr_valid`=1. On transfer with no redirect and no pending: `npc_op`=00, `npc_pc`=`pc`, `pc`←`npc_in`, then FETCH. On transfer with pending (delay-slot mode): `pc`←`redir_tgt`, clear pending, then FETCH.
- Redirect: a jump, or a branch with `br_taken`=1. `j_valid` has priority over `br_valid` when both are high. Not-taken branches are ignored.
- Redirect cycle NPC drive: `npc_pc`=`br_pc` (the jump also uses `br_pc`), `npc_op`=10 for a jump or 01 for a branch, immediates passed through. `redir_tgt`←`npc_in`. A second redirect before consumption overwrites `redir_tgt`.
- Non-redirect, non-advance cycles: `npc_op`=00, `npc_pc`=`pc`, and `npc_in` is unused.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `npc_op`=00, pending=0, state IDLE.
- First `imem_req` on the 2nd cycle after `rst` falls.
- Zero-wait memory (ack in the request cycle): `instr_valid` is high the next cycle. Peak throughput is 1 instruction per 2 cycles.
- Redirect and transfer in the same cycle: the transfer counts, and `pc`←target.
- `rst` mid-operation: return to IDLE next edge and drop any in-flight ack and pending redirect. Imem is reset by the same `rst`.
- `instr`, `instr_pc` and `instr_valid` change only at transfer, at acceptance of a new fetch, or on a kill.

## Configuration
- `FETCH_CTRL_DELAY_SLOT_EN` defined: a redirect never kills. The in-flight or held instruction (the delay slot) is delivered normally, and after its transfer `pc`←`redir_tgt`.
- Not defined: a redirect in HOLD without a simultaneous transfer drops the held instruction (`instr_valid`=0 next cycle, `pc`←target, FETCH). A redirect in FETCH sets kill, and the acked word is discarded.

## Test plan
- Reset with `RESET_PC`=0x3000, zero-wait memory, `instr_ready`=1 → `imem_addr` sequence 0x3000, 0x3004, 0x3008; `instr_valid` every 2nd cycle.
- Taken branch, `br_pc`=0x3004, `br_imm16`=0x0003, asserted in HOLD → `npc_op`=01; next fetch address 0x3014.
- Jump, `j_imm26`=0x0000100, same cycle as `br_valid`=1 → jump wins; `npc_op`=10; next fetch 0x0000_0400.
- Ack delayed 3 cycles with a taken branch during FETCH → `imem_addr` stable while waiting. Macro off: word discarded, refetch at target. Macro on: word delivered, then target fetched.
- `instr_ready`=0 for 5 cycles in HOLD → `instr`/`instr_pc` stable, no `imem_req`, then advance by +4.
- `rst` pulsed while `imem_req`=1 → all outputs at reset values next cycle; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request handshake and
// hands words to decode. Define FETCH_CTRL_DELAY_SLOT_EN to deliver delay slots.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_imm16,
    input  logic        j_valid,
    input  logic [25:0] j_imm26,
    output logic [31:0] npc_pc,
    output logic [15:0] npc_imm16,
    output logic [25:0] npc_imm26,
    output logic [1:0]  npc_op,
    input  logic [31:0] npc_in
);

`ifdef FETCH_CTRL_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_nx, instr_pc_nx;
    logic [31:0] redir_tgt, tgt_nx;
    logic        redir_pend, pend_nx;
    logic        redir, xfer;

    assign redir     = j_valid | (br_valid & br_taken);
    assign xfer      = (state == HOLD) & instr_ready;
    assign imem_addr = pc;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        instr_nx    = instr;
        instr_pc_nx = instr_pc;
        pend_nx     = redir_pend;
        tgt_nx      = redir_tgt;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        npc_imm16   = br_imm16;
        npc_imm26   = j_imm26;
        npc_pc      = pc;
        npc_op      = 2'b00;

        // Redirects always compute their target off the branch address
        if (redir) begin
            npc_pc  = br_pc;
            npc_op  = j_valid ? 2'b10 : 2'b01;
            pend_nx = 1'b1;
            tgt_nx  = npc_in;
        end

        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (!DS && (redir_pend || redir)) begin
                        // Killed fetch: drop the word and restart at the newest target
                        pc_nx   = redir ? npc_in : redir_tgt;
                        pend_nx = 1'b0;
                    end else begin
                        instr_nx    = imem_rdata;
                        instr_pc_nx = pc;
                        state_nx    = HOLD;
                    end
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (xfer) begin
                    state_nx = FETCH;
                    pend_nx  = 1'b0;
                    pc_nx    = (redir_pend && !redir) ? redir_tgt : npc_in;
                end else if (redir && !DS) begin
                    state_nx = FETCH;
                    pc_nx    = npc_in;
                    pend_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= 32'h0;
            instr_pc   <= 32'h0;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            instr      <= instr_nx;
            instr_pc   <= instr_pc_nx;
            redir_pend <= pend_nx;
            redir_tgt  <= tgt_nx;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational NPC model and a simple
// imem whose ack can be gated to create wait states.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        br_valid, br_taken, j_valid;
    logic [31:0] br_pc;
    logic [15:0] br_imm16;
    logic [25:0] j_imm26;
    logic [31:0] npc_pc, npc_in;
    logic [15:0] npc_imm16;
    logic [25:0] npc_imm26;
    logic [1:0]  npc_op;
    logic        ack_en;

    int ncmp = 0;
    int nerr = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm16(br_imm16),
        .j_valid(j_valid), .j_imm26(j_imm26),
        .npc_pc(npc_pc), .npc_imm16(npc_imm16), .npc_imm26(npc_imm26), .npc_op(npc_op), .npc_in(npc_in)
    );

    always #5 clk = ~clk;

    // Zero-wait memory when enabled; word content derived from its address
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

    logic [31:0] pc4;
    assign pc4 = npc_pc + 32'd4;
    always_comb begin
        case (npc_op)
            2'b01:   npc_in = pc4 + {{14{npc_imm16[15]}}, npc_imm16, 2'b00};
            2'b10:   npc_in = {pc4[31:28], npc_imm26, 2'b00};
            default: npc_in = pc4;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h3000);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_ipc"},   instr_pc, 32'd0);
        chk({tag, "_npcop"}, {30'b0, npc_op}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] a);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        chk({tag, "_ipc"},   instr_pc, a);
        chk({tag, "_instr"}, instr, a ^ 32'hDEAD_BEEF);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] a);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"},  imem_addr, a);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; ack_en = 1'b1; instr_ready = 1'b1;
        br_valid = 1'b0; br_taken = 1'b0; br_pc = 32'h0; br_imm16 = 16'h0;
        j_valid = 1'b0; j_imm26 = 26'h0;
        cyc(); cyc();
        chk_reset("rst");

        // Sequential fetch, zero-wait memory, one instruction per two cycles
        rst = 1'b0;
        cyc(); chk_fetch("seq0", 32'h3000);
        cyc(); chk_hold("seq0h", 32'h3000);
        chk("seq_npcop", {30'b0, npc_op}, 32'd0);
        chk("seq_npcpc", npc_pc, 32'h3000);
        cyc(); chk_fetch("seq1", 32'h3004);
        cyc(); chk_hold("seq1h", 32'h3004);
        cyc(); chk_fetch("seq2", 32'h3008);

        // Taken branch during HOLD together with a transfer
        cyc(); chk_hold("brh", 32'h3008);
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h3004; br_imm16 = 16'h0003;
        #1;
        chk("br_npcop", {30'b0, npc_op}, 32'd1);
        chk("br_npcpc", npc_pc, 32'h3004);
        chk("br_imm", {16'b0, npc_imm16}, 32'h0003);
        cyc(); br_valid = 1'b0; br_taken = 1'b0;
        chk_fetch("brf", 32'h3014);

        // Jump and taken branch together: jump wins
        cyc(); chk_hold("jh", 32'h3014);
        j_valid = 1'b1; j_imm26 = 26'h0000100;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h3014; br_imm16 = 16'h0010;
        #1;
        chk("j_npcop", {30'b0, npc_op}, 32'd2);
        chk("j_npcpc", npc_pc, 32'h3014);
        cyc(); j_valid = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        chk_fetch("jf", 32'h0000_0400);

        // Delayed ack with a taken branch arriving while the fetch waits
        ack_en = 1'b0;
        cyc(); chk_fetch("dly0", 32'h0400);
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h0400; br_imm16 = 16'h0010;
        #1; chk("dly_npcop", {30'b0, npc_op}, 32'd1);
        cyc(); br_valid = 1'b0; br_taken = 1'b0;
        chk_fetch("dly1", 32'h0400);
        cyc(); chk_fetch("dly2", 32'h0400);
        ack_en = 1'b1;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        cyc(); chk_hold("ds_slot", 32'h0400);
        cyc(); chk_fetch("ds_tgt", 32'h0444);
        cyc(); chk_hold("ds_tgth", 32'h0444);
`else
        cyc(); chk_fetch("kill_tgt", 32'h0444);
        cyc(); chk_hold("kill_tgth", 32'h0444);
`endif

        // Decode stall for five cycles holds the instruction steady
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk_hold("stall", 32'h0444);
        end
        instr_ready = 1'b1;
        cyc(); chk_fetch("post_stall", 32'h0448);

        // Pending redirect then reset mid-fetch: both are dropped
        ack_en = 1'b0;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h0448; br_imm16 = 16'h0001;
        cyc(); br_valid = 1'b0; br_taken = 1'b0;
        chk_fetch("pre_rst", 32'h0448);
        rst = 1'b1;
        cyc(); chk_reset("mid_rst");
        rst = 1'b0; ack_en = 1'b1;
        cyc(); chk_fetch("rst_f", 32'h3000);
        cyc(); chk_hold("rst_h", 32'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
